// File: rtl/cme_ip_tx_pkg_v3.sv
// Shared constants, state encoding and helpers for the TX frame reader.
package cme_ip_tx_pkg_v3;

    localparam int WORDS_PER_BANK = 384;
    localparam int MAX_LEN        = WORDS_PER_BANK * 4;
    localparam int MIN_LEN        = 60;
    localparam int AW             = 9;
    localparam int LEN_W          = 11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } tx_state_t;

    typedef logic [1:0] lane_t;

    // Number of 32-bit words holding len bytes, rounded up.
    function automatic logic [AW-1:0] word_count(input logic [LEN_W-1:0] len);
        logic [LEN_W:0] len_p3;
        len_p3 = {1'b0, len} + (LEN_W+1)'(3);
        return AW'(len_p3 >> 2);
    endfunction

endpackage

// File: rtl/cme_ip_tx_frame_reader_v3_if.sv
// MAC transmit interface: byte stream with valid/ready handshake and framing.
interface cme_ip_tx_frame_reader_v3_if;
    logic [7:0] mti_data;
    logic       mti_valid;
    logic       mti_sop;
    logic       mti_eop;
    logic       mti_rdy;

    modport master (output mti_data, output mti_valid, output mti_sop,
                    output mti_eop, input mti_rdy);
    modport slave  (input mti_data, input mti_valid, input mti_sop,
                    input mti_eop, output mti_rdy);
endinterface

// File: rtl/cme_ip_tx_word_buf2_v3.sv
// Two-entry 32-bit FIFO between the RAM read port and the byte serializer.
module cme_ip_tx_word_buf2_v3 (
    input  logic        clkr,
    input  logic        rst,
    input  logic        clr,
    input  logic        push,
    input  logic        pop,
    input  logic [31:0] din,
    output logic [31:0] head,
    output logic [1:0]  count
);

    logic [31:0] mem [2];
    logic        wptr;
    logic        rptr;

    always_ff @(posedge clkr or posedge rst) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wptr   <= 1'b0;
            rptr   <= 1'b0;
            count  <= 2'd0;
        end else if (clr) begin
            wptr  <= 1'b0;
            rptr  <= 1'b0;
            count <= 2'd0;
        end else begin
            if (push) begin
                mem[wptr] <= din;
                wptr      <= ~wptr;
            end
            if (pop) begin
                rptr <= ~rptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: ;
            endcase
        end
    end

    assign head = mem[rptr];

endmodule

// File: rtl/cme_ip_tx_frame_reader_v3.sv
// Reads one frame from the ping-pong TX RAM and streams it byte-wise to the MAC.
// Build option CME_TX_READER_PAD_EN: zero-pad short frames up to MIN_LEN bytes.
//
//   state | meaning
//   IDLE  | waiting for tx_start_i; only state that accepts a start
//   RUN   | fetching words and serializing bytes
//   DONE  | one cycle, pulses tx_done_o
module cme_ip_tx_frame_reader_v3
    import cme_ip_tx_pkg_v3::*;
(
    input  logic             clkr,
    input  logic             rst,
    input  logic             tx_start_i,
    input  logic [LEN_W-1:0] tx_len_i,
    input  logic             tx_bank_i,
    output logic             tx_busy_o,
    output logic             tx_done_o,
    output logic             tx_err_o,
    output logic             cer_o,
    output logic [AW-1:0]    ar_o,
    output logic             ram_adv_o,
    input  logic [31:0]      qr_i,
    output logic             rd_ram_sel_o,
    cme_ip_tx_frame_reader_v3_if.master mti
);

    tx_state_t        state, state_nxt;
    logic [LEN_W-1:0] len_q;
    logic [AW-1:0]    words_q;
    logic [AW-1:0]    rd_cnt;
    logic             rd_pend;
    logic [LEN_W-1:0] byte_cnt;
    lane_t            lane;

    logic [31:0]      buf_head;
    logic [1:0]       buf_cnt;
    logic [1:0]       cnt_nxt;

    logic             len_legal, start_ok;
    logic             in_data, xfer, push, pop, cer_nxt;
    logic [LEN_W-1:0] last_cnt;
    logic [AW-1:0]    rd_base, words_nxt;

    cme_ip_tx_word_buf2_v3 u_buf (
        .clkr  (clkr),
        .rst   (rst),
        .clr   (start_ok),
        .push  (push),
        .pop   (pop),
        .din   (qr_i),
        .head  (buf_head),
        .count (buf_cnt)
    );

    always_comb begin
        len_legal = (tx_len_i != '0) && (tx_len_i <= LEN_W'(MAX_LEN));
        start_ok  = tx_start_i && (state == IDLE) && len_legal;

`ifdef CME_TX_READER_PAD_EN
        in_data  = (byte_cnt < len_q);
        last_cnt = (len_q < LEN_W'(MIN_LEN)) ? LEN_W'(MIN_LEN - 1) : len_q - LEN_W'(1);
`else
        in_data  = 1'b1;
        last_cnt = len_q - LEN_W'(1);
`endif

        mti.mti_valid = (state == RUN) && ((buf_cnt != 2'd0) || !in_data);
        mti.mti_data  = in_data ? 8'(buf_head >> {lane, 3'b000}) : 8'h00;
        mti.mti_sop   = mti.mti_valid && (byte_cnt == '0);
        mti.mti_eop   = mti.mti_valid && (byte_cnt == last_cnt);

        xfer = mti.mti_valid && mti.mti_rdy;
        // A word leaves the buffer after its 4th byte, or early on the frame's last data byte.
        pop  = xfer && in_data && ((lane == 2'd3) || (byte_cnt == len_q - LEN_W'(1)));
        push = rd_pend;
        cnt_nxt = buf_cnt + {1'b0, push} - {1'b0, pop};

        state_nxt = state;
        case (state)
            IDLE:    if (start_ok) state_nxt = RUN;
            RUN:     if (xfer && mti.mti_eop) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        rd_base   = (state == IDLE) ? '0 : rd_cnt;
        words_nxt = (state == IDLE) ? word_count(tx_len_i) : words_q;
        // The read in flight this cycle still needs a slot, so count it against the buffer.
        cer_nxt   = (state_nxt == RUN) && (rd_base < words_nxt) &&
                    (({1'b0, cnt_nxt} + {2'b00, cer_o}) < 3'd2);
    end

    always_ff @(posedge clkr or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            len_q        <= '0;
            words_q      <= '0;
            rd_cnt       <= '0;
            rd_pend      <= 1'b0;
            byte_cnt     <= '0;
            lane         <= '0;
            cer_o        <= 1'b0;
            ar_o         <= '0;
            rd_ram_sel_o <= 1'b0;
            tx_err_o     <= 1'b0;
        end else begin
            state    <= state_nxt;
            tx_err_o <= tx_start_i && !start_ok;
            cer_o    <= cer_nxt;
            rd_pend  <= cer_o;
            if (cer_nxt) begin
                ar_o   <= rd_base;
                rd_cnt <= rd_base + AW'(1);
            end
            if (start_ok) begin
                len_q        <= tx_len_i;
                words_q      <= word_count(tx_len_i);
                rd_ram_sel_o <= tx_bank_i;
                byte_cnt     <= '0;
                lane         <= '0;
            end else if (xfer) begin
                byte_cnt <= byte_cnt + LEN_W'(1);
                lane     <= lane + lane_t'(1);
            end
        end
    end

    assign tx_busy_o = (state == RUN);
    assign tx_done_o = (state == DONE);
    assign ram_adv_o = cer_o;

endmodule

// File: tb/tb_cme_ip_tx_frame_reader_v3.sv
// Directed bench for the TX frame reader with a behavioural two-bank RAM.
module tb_cme_ip_tx_frame_reader_v3;
    import cme_ip_tx_pkg_v3::*;

`ifdef CME_TX_READER_PAD_EN
    localparam int PAD_ON = 1;
`else
    localparam int PAD_ON = 0;
`endif

    logic             clkr = 1'b0;
    logic             rst;
    logic             tx_start_i;
    logic [LEN_W-1:0] tx_len_i;
    logic             tx_bank_i;
    logic             tx_busy_o, tx_done_o, tx_err_o;
    logic             cer_o, ram_adv_o, rd_ram_sel_o;
    logic [AW-1:0]    ar_o;
    logic [31:0]      qr_i = '0;

    cme_ip_tx_frame_reader_v3_if mti_if ();

    cme_ip_tx_frame_reader_v3 dut (
        .clkr         (clkr),
        .rst          (rst),
        .tx_start_i   (tx_start_i),
        .tx_len_i     (tx_len_i),
        .tx_bank_i    (tx_bank_i),
        .tx_busy_o    (tx_busy_o),
        .tx_done_o    (tx_done_o),
        .tx_err_o     (tx_err_o),
        .cer_o        (cer_o),
        .ar_o         (ar_o),
        .ram_adv_o    (ram_adv_o),
        .qr_i         (qr_i),
        .rd_ram_sel_o (rd_ram_sel_o),
        .mti          (mti_if)
    );

    always #5 clkr = ~clkr;

    int n_chk = 0, n_pass = 0, n_fail = 0;
    int cyc = 0;
    bit bp_mode = 1'b0;

    logic [7:0] xb[$];
    bit         xsop[$], xeop[$];
    int         rd_addr[$];
    int first_cer, first_val, n_err, err_cyc, n_done, done_cyc, hold_bad, adv_bad;
    bit busy_at_done, prev_hold;
    logic [7:0] pd;
    logic ps, pe;

    function automatic logic [31:0] word_pat(input logic b, input int a);
        if (!b && a == 0) return 32'h44332211;
        if (!b && a == 1) return 32'h88776655;
        return 32'(a * 32'h01030507) ^ (b ? 32'hDEADBEEF : 32'h12345678);
    endfunction

    function automatic logic [7:0] exp_byte(input logic b, input int k);
        return 8'(word_pat(b, k / 4) >> (8 * (k % 4)));
    endfunction

    always @(posedge clkr) cyc <= cyc + 1;

    always @(posedge clkr) if (cer_o) qr_i <= word_pat(rd_ram_sel_o, int'(ar_o));

    always @(posedge clkr) begin
        #2;
        mti_if.mti_rdy = bp_mode ? ~mti_if.mti_rdy : 1'b1;
    end

    always @(negedge clkr) begin
        if (mti_if.mti_valid && mti_if.mti_rdy) begin
            xb.push_back(mti_if.mti_data);
            xsop.push_back(mti_if.mti_sop);
            xeop.push_back(mti_if.mti_eop);
        end
        if (mti_if.mti_valid && first_val < 0) first_val = cyc;
        if (cer_o) begin
            rd_addr.push_back(int'(ar_o));
            if (first_cer < 0) first_cer = cyc;
        end
        if (cer_o !== ram_adv_o) adv_bad++;
        if (tx_err_o) begin n_err++; err_cyc = cyc; end
        if (tx_done_o) begin n_done++; done_cyc = cyc; busy_at_done = tx_busy_o; end
        if (prev_hold && (!mti_if.mti_valid || mti_if.mti_data !== pd ||
                          mti_if.mti_sop !== ps || mti_if.mti_eop !== pe)) hold_bad++;
        prev_hold = mti_if.mti_valid && !mti_if.mti_rdy;
        pd = mti_if.mti_data; ps = mti_if.mti_sop; pe = mti_if.mti_eop;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_mon();
        xb.delete(); xsop.delete(); xeop.delete(); rd_addr.delete();
        first_cer = -1; first_val = -1; n_err = 0; err_cyc = -1;
        n_done = 0; done_cyc = -1; hold_bad = 0; adv_bad = 0;
        busy_at_done = 1'b0; prev_hold = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clkr);
        #1;
    endtask

    task automatic start(input int len, input logic bank, output int t);
        tx_start_i = 1'b1;
        tx_len_i   = LEN_W'(len);
        tx_bank_i  = bank;
        t = cyc;
        @(posedge clkr); #1;
        tx_start_i = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clkr);
            if (tx_done_o) ok = 1'b1;
        end
        chk(tag, 32'(ok), 32'd1);
        @(posedge clkr); #1;
    endtask

    task automatic chk_frame(input string tag, input logic bank, input int len, input int total);
        int bad = 0, bsop = 0, beop = 0;
        for (int k = 0; k < xb.size(); k++) begin
            if (xb[k] !== ((k < len) ? exp_byte(bank, k) : 8'h00)) bad++;
            if (xsop[k] != (k == 0)) bsop++;
            if (xeop[k] != (k == total - 1)) beop++;
        end
        chk({tag, "_count"}, 32'(xb.size()), 32'(total));
        chk({tag, "_bytes"}, 32'(bad), 32'd0);
        chk({tag, "_sop"},   32'(bsop), 32'd0);
        chk({tag, "_eop"},   32'(beop), 32'd0);
    endtask

    function automatic logic [31:0] out_vec();
        return {cer_o, ram_adv_o, ar_o, tx_busy_o, tx_done_o, tx_err_o, rd_ram_sel_o,
                mti_if.mti_valid, mti_if.mti_sop, mti_if.mti_eop, mti_if.mti_data};
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t, t0, total, bad, eops;
        bit ok;
        rst = 1'b1; tx_start_i = 1'b0; tx_len_i = '0; tx_bank_i = 1'b0;
        clr_mon();
        idle(3);
        chk("reset_outputs", out_vec(), 32'd0);
        rst = 1'b0;
        idle(2);

        // Basic 8-byte frame, bank 0
        clr_mon();
        start(8, 1'b0, t);
        wait_done(40, "basic_done");
        idle(2);
        chk("basic_first_cer", 32'(first_cer), 32'(t + 1));
        chk("basic_first_valid", 32'(first_val), 32'(t + 3));
        chk("basic_done_cycle", 32'(done_cyc), 32'(t + 11));
        chk("basic_nreads", 32'(rd_addr.size()), 32'd2);
        if (rd_addr.size() == 2) begin
            chk("basic_addr0", 32'(rd_addr[0]), 32'd0);
            chk("basic_addr1", 32'(rd_addr[1]), 32'd1);
        end
        if (xb.size() == 8) begin
            chk("basic_byte0", 32'(xb[0]), 32'h11);
            chk("basic_byte7", 32'(xb[7]), 32'h88);
        end
        chk_frame("basic", 1'b0, 8, 8);
        chk("basic_busy_at_done", 32'(busy_at_done), 32'd0);
        chk("basic_adv_eq_cer", 32'(adv_bad), 32'd0);

        // Partial last word
        clr_mon();
        total = PAD_ON ? MIN_LEN : 5;
        start(5, 1'b0, t);
        wait_done(120, "part_done");
        idle(2);
        chk("part_nreads", 32'(rd_addr.size()), 32'd2);
        chk("part_done_cycle", 32'(done_cyc), 32'(t + 3 + total));
        if (xb.size() >= 5) chk("part_byte4", 32'(xb[4]), 32'h55);
        chk_frame("part", 1'b0, 5, total);

        // Backpressure, ready toggling every cycle
        clr_mon();
        bp_mode = 1'b1;
        start(8, 1'b0, t);
        wait_done(80, "bp_done");
        bp_mode = 1'b0;
        idle(2);
        chk("bp_hold_stable", 32'(hold_bad), 32'd0);
        chk_frame("bp", 1'b0, 8, 8);

        // Full-size frame, bank 1
        clr_mon();
        start(MAX_LEN, 1'b1, t);
        wait_done(2000, "full_done");
        idle(2);
        chk("full_bank_sel", 32'(rd_ram_sel_o), 32'd1);
        chk("full_nreads", 32'(rd_addr.size()), 32'(WORDS_PER_BANK));
        bad = 0;
        foreach (rd_addr[i]) if (rd_addr[i] != i) bad++;
        chk("full_addr_sweep", 32'(bad), 32'd0);
        chk("full_done_cycle", 32'(done_cyc), 32'(t + 3 + MAX_LEN));
        chk("full_busy_after", 32'(tx_busy_o), 32'd0);
        chk_frame("full", 1'b1, MAX_LEN, MAX_LEN);

        // Rejected starts: zero length, over-length, start while busy
        clr_mon();
        start(0, 1'b0, t);
        idle(4);
        chk("rej0_err", 32'(n_err), 32'd1);
        chk("rej0_err_cycle", 32'(err_cyc), 32'(t + 1));
        chk("rej0_quiet", {16'(rd_addr.size()), 16'(xb.size())}, 32'd0);
        chk("rej0_valid_never", 32'(first_val), 32'hFFFF_FFFF);
        chk("rej0_sel_kept", 32'(rd_ram_sel_o), 32'd1);

        clr_mon();
        start(MAX_LEN + 1, 1'b0, t);
        idle(4);
        chk("rej1537_err", 32'(n_err), 32'd1);
        chk("rej1537_quiet", {16'(rd_addr.size()), 16'(xb.size())}, 32'd0);
        chk("rej1537_busy", 32'(tx_busy_o), 32'd0);

        clr_mon();
        start(8, 1'b0, t0);
        idle(1);
        start(4, 1'b1, t);
        wait_done(40, "rejbusy_done");
        idle(2);
        chk("rejbusy_err", 32'(n_err), 32'd1);
        chk("rejbusy_sel", 32'(rd_ram_sel_o), 32'd0);
        chk("rejbusy_nreads", 32'(rd_addr.size()), 32'd2);
        chk("rejbusy_done_cycle", 32'(done_cyc), 32'(t0 + 11));
        chk_frame("rejbusy", 1'b0, 8, 8);

        // Reset in the middle of a long frame
        clr_mon();
        start(MAX_LEN, 1'b1, t);
        ok = 1'b0;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(negedge clkr);
            if (xb.size() >= 100) ok = 1'b1;
        end
        chk("midrst_reach100", 32'(ok), 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_outputs", out_vec(), 32'd0);
        eops = 0;
        foreach (xeop[i]) if (xeop[i]) eops++;
        chk("midrst_no_eop", 32'(eops), 32'd0);
        @(posedge clkr); #1;
        rst = 1'b0;
        idle(2);
        clr_mon();
        start(8, 1'b0, t);
        wait_done(40, "after_rst_done");
        idle(2);
        chk("after_rst_done_cycle", 32'(done_cyc), 32'(t + 11));
        chk("after_rst_sel", 32'(rd_ram_sel_o), 32'd0);
        chk_frame("after_rst", 1'b0, 8, 8);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
